// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 keyboard receiver (scan code set 2) decoding W/A/S/D
// into a held 8-bit HID-style keycode for the ball motion logic.
//
// Ports:
//   Clk           system clock
//   Reset_n       asynchronous reset, active-low
//   PS2_CLK       raw PS/2 clock pin (asynchronous)
//   PS2_DATA      raw PS/2 data pin (asynchronous)
//   keycode       currently held mapped key, 0x00 when none
//   keycode_valid one-cycle pulse whenever keycode changes
//   frame_err     one-cycle pulse on start/parity/stop/timeout error
//
// Optional feature: define PS2_ARROW_KEYS_EN to map E0-prefixed arrow
// keys onto the same outputs as W/A/S/D; otherwise E0 codes are dropped.
module ps2_keycode #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] keycode,
  output logic       keycode_valid,
  output logic       frame_err
);

  localparam int unsigned FW = 4;   // filter counter width (FILTER_LEN <= 15)
  localparam int unsigned TW = 16;  // timeout counter width
  localparam int unsigned BW = 3;   // data bit counter width

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_bit_edge;
  logic          r_bit_data;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic          r_par, w_par_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic          w_err;
  logic          w_clr_flags;
  logic          w_byte_ok;

  logic          r_brk, w_brk_nxt;
  logic          r_ext, w_ext_nxt;
  logic [7:0]    w_key_nxt;
  logic [7:0]    w_mapped;

  // Make-code to output mapping; 0x00 means unmapped.
  function automatic logic [7:0] map_code(input logic [7:0] code, input logic ext);
    logic [7:0] res;
    res = 8'h00;
    if (!ext) begin
      case (code)
        8'h1D:   res = 8'h1A;
        8'h1C:   res = 8'h04;
        8'h1B:   res = 8'h16;
        8'h23:   res = 8'h07;
        default: res = 8'h00;
      endcase
    end else begin
`ifdef PS2_ARROW_KEYS_EN
      case (code)
        8'h75:   res = 8'h1A;
        8'h6B:   res = 8'h04;
        8'h72:   res = 8'h16;
        8'h74:   res = 8'h07;
        default: res = 8'h00;
      endcase
`else
      res = 8'h00;
`endif
    end
    return res;
  endfunction

  // Synchronizers and PS/2 clock glitch filter; bit edge is a filtered fall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_bit_edge <= 1'b0;
      r_bit_data <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
      r_bit_data <= r_dat_sync[1];
      r_bit_edge <= 1'b0;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
        r_bit_edge <= r_clk_filt;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Receive FSM state register and frame datapath.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bcnt   <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_par    <= w_par_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end

  // Receive FSM next state; a bit edge takes priority over a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bcnt_nxt  = r_bcnt;
    w_par_nxt   = r_par;
    w_to_nxt    = r_to_cnt;
    w_err       = 1'b0;
    w_clr_flags = 1'b0;
    w_byte_ok   = 1'b0;
    if (r_bit_edge) begin
      w_to_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (!r_bit_data) begin
            w_state_nxt = S_DATA;
            w_bcnt_nxt  = '0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_DATA: begin
          w_shift_nxt = {r_bit_data, r_shift[7:1]};
          w_bcnt_nxt  = r_bcnt + 1'b1;
          if (r_bcnt == BW'(7)) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_par_nxt   = r_bit_data;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (r_bit_data && (^{r_shift, r_par})) begin
            w_byte_ok = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_clr_flags = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        w_err       = 1'b1;
        w_clr_flags = 1'b1;
        w_state_nxt = S_IDLE;
        w_shift_nxt = '0;
        w_bcnt_nxt  = '0;
        w_to_nxt    = '0;
      end else begin
        w_to_nxt = r_to_cnt + 1'b1;
      end
    end
  end

  // Prefix flags and held keycode update for an accepted byte.
  always_comb begin
    w_key_nxt = keycode;
    w_brk_nxt = r_brk;
    w_ext_nxt = r_ext;
    w_mapped  = map_code(r_shift, r_ext);
    if (w_clr_flags) begin
      w_brk_nxt = 1'b0;
      w_ext_nxt = 1'b0;
    end else if (w_byte_ok) begin
      if (r_shift == 8'hF0) begin
        w_brk_nxt = 1'b1;
      end else if (r_shift == 8'hE0) begin
        w_ext_nxt = 1'b1;
      end else begin
        if (w_mapped != 8'h00) begin
          if (!r_brk)                  w_key_nxt = w_mapped;
          else if (keycode == w_mapped) w_key_nxt = 8'h00;
        end
        w_brk_nxt = 1'b0;
        w_ext_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode       <= 8'h00;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
      r_brk         <= 1'b0;
      r_ext         <= 1'b0;
    end else begin
      keycode       <= w_key_nxt;
      keycode_valid <= (w_key_nxt != keycode);
      frame_err     <= w_err;
      r_brk         <= w_brk_nxt;
      r_ext         <= w_ext_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: randomized PS/2 frame stimulus checked against a
// behavioural key-state model (held key, prefix flags, pulse counts).
module tb_ps2_keycode;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TOUT = 5000;
  localparam int unsigned HP   = 12;  // PS/2 half-period in Clk cycles

  logic       Clk;
  logic       Reset_n;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] keycode;
  logic       keycode_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_errs   = 0;
  int n_vld    = 0;
  int n_ferr   = 0;

  // reference model state
  logic [7:0] m_key;
  bit         m_brk, m_ext;
  int         m_vld, m_ferr;

  ps2_keycode #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .keycode(keycode), .keycode_valid(keycode_valid), .frame_err(frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // pulse counters sampled mid-cycle
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (keycode_valid) n_vld++;
      if (frame_err)     n_ferr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] model_map(input logic [7:0] c, input bit e);
    logic [7:0] mk  [4];
    logic [7:0] arw [4];
    logic [7:0] outv[4];
    mk   = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    arw  = '{8'h75, 8'h6B, 8'h72, 8'h74};
    outv = '{8'h1A, 8'h04, 8'h16, 8'h07};
    for (int i = 0; i < 4; i++) begin
      if (!e && c == mk[i]) return outv[i];
`ifdef PS2_ARROW_KEYS_EN
      if (e && c == arw[i]) return outv[i];
`endif
    end
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [7:0] old, m;
    old = m_key;
    if (bad) begin
      m_ferr++;
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      m = model_map(b, m_ext);
      if (m != 8'h00) begin
        if (!m_brk) m_key = m;
        else if (m_key == m) m_key = 8'h00;
      end
      m_brk = 0;
      m_ext = 0;
    end
    if (m_key != old) m_vld++;
  endtask

  // Drive the first n bits of an 11-bit frame; optionally glitch PS2_CLK
  // during data bits and measure stop-edge to keycode latency.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch,
                           input bit measure);
    logic [7:0] old;
    int lat;
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        wait_clks(3); PS2_CLK = 1'b0; wait_clks(1); PS2_CLK = 1'b1; wait_clks(HP - 4);
      end else begin
        wait_clks(HP);
      end
      if (measure && i == 10) begin
        old = keycode;
        PS2_CLK = 1'b0;
        lat = 0;
        while (keycode == old && lat < 40) begin
          wait_clks(1);
          lat++;
        end
        chk("stop_latency", lat, 2 + FLEN + 1);
        chk("valid_with_key", keycode_valid, 1'b1);
        wait_clks(HP);
      end else begin
        PS2_CLK = 1'b0;
        if (glitch && i >= 1 && i <= 8) begin
          wait_clks(3); PS2_CLK = 1'b1; wait_clks(1); PS2_CLK = 1'b0; wait_clks(HP - 4);
        end else begin
          wait_clks(HP);
        end
      end
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = ~(^b);
    if (bad) par = ~par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic frame(input string tag, input logic [7:0] b, input bit bad,
                       input bit glitch, input bit measure);
    send_bits(mk_frame(b, bad), 11, glitch, measure);
    model_byte(b, bad);
    wait_clks(20);
    chk({tag, "_key"}, keycode, m_key);
    chk({tag, "_vld"}, n_vld, m_vld);
    chk({tag, "_err"}, n_ferr, m_ferr);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    wait_clks(3);
    m_key = 8'h00; m_brk = 0; m_ext = 0;
    chk("rst_key", keycode, 8'h00);
    chk("rst_vld", keycode_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    Reset_n = 1'b1;
    wait_clks(3);
  endtask

  initial begin
    logic [7:0] pool[11];
    logic [7:0] b;
    bit bad, gl;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h00};
    m_vld = 0; m_ferr = 0; m_key = 8'h00; m_brk = 0; m_ext = 0;
    PS2_CLK = 1'b1; PS2_DATA = 1'b1; Reset_n = 1'b1;
    wait_clks(2);
    do_reset();

    frame("a_make", 8'h1C, 0, 0, 1);
    frame("w_make", 8'h1D, 0, 0, 0);
    frame("w_brk0", 8'hF0, 0, 0, 0);
    frame("w_brk1", 8'h1D, 0, 0, 0);
    frame("d_make", 8'h23, 0, 0, 0);
    frame("s_make", 8'h1B, 0, 0, 0);
    frame("d_brk0", 8'hF0, 0, 0, 0);
    frame("d_brk1", 8'h23, 0, 0, 0);
    frame("s_rept", 8'h1B, 0, 0, 0);
    frame("s_brk0", 8'hF0, 0, 0, 0);
    frame("s_brk1", 8'h1B, 0, 0, 0);
    frame("bad_par", 8'h1C, 1, 0, 0);

    // stall after start + 4 data bits
    send_bits(mk_frame(8'h23, 0), 5, 0, 0);
    wait_clks(TOUT + 200);
    m_ferr++;
    chk("tout_err", n_ferr, m_ferr);
    chk("tout_key", keycode, m_key);
    frame("after_to", 8'h23, 0, 0, 0);

    frame("ext0", 8'hE0, 0, 0, 0);
    frame("ext1", 8'h74, 0, 0, 0);
    frame("glitch", 8'h1C, 0, 1, 0);

    // reset in the middle of a frame, then a fresh frame
    send_bits(mk_frame(8'h1D, 0), 4, 0, 0);
    do_reset();
    frame("post_rst", 8'h1B, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      b = pool[$urandom_range(0, 10)];
      if (b == 8'h00) b = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      gl  = ($urandom_range(0, 3) == 0);
      frame("rnd", b, bad, gl, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
